regfile_sb: RTL and testbench

Next-generation CPU register file with a dedicated write-back port, an async-clearable array, optional write-to-read bypass, and an integrated busy-bit scoreboard. Decode marks a destination busy at issue, and write-back clears it. Read ports report operand readiness so the issue stage can stall on RAW hazards. The block sits between decode/issue and the ALU write-back path.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: CPU register file with a write-back port, optional write-to-read
// bypass and an integrated busy-bit scoreboard for RAW/WAW hazard tracking.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_BITS-1:0]       rd_a_index,
    input  logic [REG_BITS-1:0]       rd_b_index,
    output logic [WIDTH-1:0]          rd_a_data,
    output logic [WIDTH-1:0]          rd_b_data,
    output logic                      rd_a_ready,
    output logic                      rd_b_ready,
    input  logic                      wr_en,
    input  logic [REG_BITS-1:0]       wr_index,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      issue_en,
    input  logic [REG_BITS-1:0]       issue_index,
    output logic                      issue_stall,
    input  logic                      flush,
    output logic [(1<<REG_BITS)-1:0]  busy_vec,
    output logic [REG_BITS:0]         busy_count,
    output logic                      err_wr_idle
);

    localparam int NREGS = 1 << REG_BITS;

    logic [WIDTH-1:0]    r_regs [NREGS];
    logic [NREGS-1:0]    r_busy;
    logic [REG_BITS:0]   r_busy_count;
    logic                r_err_wr_idle;

    logic                w_wr_valid;
    logic                w_wr_hits_issue;
    logic                w_issue_stall;
    logic                w_issue_accept;
    logic                w_err_next;
    logic [NREGS-1:0]    w_busy_next;
    logic [REG_BITS:0]   w_count_next;
    logic                w_a_bypass;
    logic                w_b_bypass;

    assign w_wr_valid      = wr_en & (wr_index != '0);
    assign w_wr_hits_issue = wr_en & (wr_index == issue_index);

    // A same-cycle write-back to the busy destination retires the old producer,
    // so the new issue can take over the register without a WAW stall.
    assign w_issue_stall  = issue_en & (issue_index != '0) & r_busy[issue_index]
                          & ~w_wr_hits_issue & ~flush;
    assign w_issue_accept = issue_en & ~w_issue_stall & (issue_index != '0);

    assign w_err_next = w_wr_valid & ~r_busy[wr_index] & ~flush;

    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (flush) begin
                w_busy_next[i] = 1'b0;
            end else if (w_issue_accept && (issue_index == REG_BITS'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (wr_en && (wr_index == REG_BITS'(i))) begin
                w_busy_next[i] = 1'b0;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    // Popcount of the next busy vector so the count lands on the same edge.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_count_next = w_count_next + (REG_BITS+1)'(w_busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wr_index] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy        <= '0;
            r_busy_count  <= '0;
            r_err_wr_idle <= 1'b0;
        end else begin
            r_busy        <= w_busy_next;
            r_busy_count  <= w_count_next;
            r_err_wr_idle <= w_err_next;
        end
    end

    assign w_a_bypass = BYPASS & wr_en & (wr_index == rd_a_index);
    assign w_b_bypass = BYPASS & wr_en & (wr_index == rd_b_index);

    assign rd_a_data  = (rd_a_index == '0) ? '0 :
                        w_a_bypass         ? wr_data : r_regs[rd_a_index];
    assign rd_a_ready = (rd_a_index == '0) | w_a_bypass | ~r_busy[rd_a_index];

    assign rd_b_data  = (rd_b_index == '0) ? '0 :
                        w_b_bypass         ? wr_data : r_regs[rd_b_index];
    assign rd_b_ready = (rd_b_index == '0) | w_b_bypass | ~r_busy[rd_b_index];

    assign issue_stall = w_issue_stall;
    assign busy_vec    = r_busy;
    assign busy_count  = r_busy_count;
    assign err_wr_idle = r_err_wr_idle;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors against a bypassing and a non-bypassing
// regfile_sb driven by the same stimulus.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  rdAIndex, rdBIndex, wrIndex, issueIndex;
    logic        wrEn, issueEn, flush;
    logic [15:0] wrData;

    logic [15:0] byARdData, byBRdData, nbARdData, nbBRdData;
    logic        byAReady, byBReady, nbAReady, nbBReady;
    logic        byStall, nbStall, byErr, nbErr;
    logic [15:0] byBusyVec, nbBusyVec;
    logic [4:0]  byBusyCount, nbBusyCount;

    int testsRun = 0;
    int testsFailed = 0;

    regfile_sb #(.WIDTH(16), .REG_BITS(4), .BYPASS(1'b1)) dutBypass (
        .clk(clk), .reset_n(reset_n),
        .rd_a_index(rdAIndex), .rd_b_index(rdBIndex),
        .rd_a_data(byARdData), .rd_b_data(byBRdData),
        .rd_a_ready(byAReady), .rd_b_ready(byBReady),
        .wr_en(wrEn), .wr_index(wrIndex), .wr_data(wrData),
        .issue_en(issueEn), .issue_index(issueIndex), .issue_stall(byStall),
        .flush(flush), .busy_vec(byBusyVec), .busy_count(byBusyCount),
        .err_wr_idle(byErr)
    );

    regfile_sb #(.WIDTH(16), .REG_BITS(4), .BYPASS(1'b0)) dutNoBypass (
        .clk(clk), .reset_n(reset_n),
        .rd_a_index(rdAIndex), .rd_b_index(rdBIndex),
        .rd_a_data(nbARdData), .rd_b_data(nbBRdData),
        .rd_a_ready(nbAReady), .rd_b_ready(nbBReady),
        .wr_en(wrEn), .wr_index(wrIndex), .wr_data(wrData),
        .issue_en(issueEn), .issue_index(issueIndex), .issue_stall(nbStall),
        .flush(flush), .busy_vec(nbBusyVec), .busy_count(nbBusyCount),
        .err_wr_idle(nbErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wi,
                                 input logic [15:0] wd, input logic ie,
                                 input logic [3:0] ii, input logic fl);
        wrEn = we; wrIndex = wi; wrData = wd;
        issueEn = ie; issueIndex = ii; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        rdAIndex = '0; rdBIndex = '0;
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // All indices read back as zero and ready after reset
        for (int i = 0; i < 16; i++) begin
            rdAIndex = 4'(i);
            rdBIndex = 4'(15 - i);
            #1;
            checkOutput($sformatf("rstDataA%0d", i), 32'(byARdData), 32'h0);
            checkOutput($sformatf("rstDataB%0d", i), 32'(byBRdData), 32'h0);
            checkOutput($sformatf("rstRdyA%0d", i), 32'(byAReady), 32'h1);
            checkOutput($sformatf("rstRdyB%0d", i), 32'(byBReady), 32'h1);
        end
        checkOutput("rstBusyVec", 32'(byBusyVec), 32'h0);
        checkOutput("rstBusyCount", 32'(byBusyCount), 32'h0);
        checkOutput("rstErr", 32'(byErr), 32'h0);

        // Issue R3, RAW stall visible on both ports, bypassed write-back
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0);
        checkOutput("issR3Stall", 32'(byStall), 32'h0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("issR3BusyVec", 32'(byBusyVec), 32'h0008);
        checkOutput("issR3Count", 32'(byBusyCount), 32'h1);
        rdAIndex = 4'd3; rdBIndex = 4'd3;
        #1;
        checkOutput("r3ReadyA", 32'(byAReady), 32'h0);
        checkOutput("r3ReadyB", 32'(byBReady), 32'h0);
        applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0);
        checkOutput("r3BypassData", 32'(byARdData), 32'hBEEF);
        checkOutput("r3BypassReady", 32'(byAReady), 32'h1);
        checkOutput("r3NoBypassData", 32'(nbARdData), 32'h0);
        checkOutput("r3NoBypassReady", 32'(nbAReady), 32'h0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("r3WbBusyVec", 32'(byBusyVec), 32'h0);
        checkOutput("r3WbCount", 32'(byBusyCount), 32'h0);
        checkOutput("r3WbErr", 32'(byErr), 32'h0);
        checkOutput("r3WbData", 32'(byARdData), 32'hBEEF);
        checkOutput("r3WbReady", 32'(byAReady), 32'h1);

        // WAW stall on busy R5, then issue+write to R5 accepted together
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0);
        tick();
        checkOutput("r5BusyVec", 32'(byBusyVec), 32'h0020);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0);
        checkOutput("r5WawStall", 32'(byStall), 32'h1);
        tick();
        checkOutput("r5StallCount", 32'(byBusyCount), 32'h1);
        applyStimulus(1'b1, 4'd5, 16'h5555, 1'b1, 4'd5, 1'b0);
        checkOutput("r5WrIssStall", 32'(byStall), 32'h0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("r5StillBusy", 32'(byBusyVec), 32'h0020);
        checkOutput("r5WrIssCount", 32'(byBusyCount), 32'h1);
        checkOutput("r5WrIssErr", 32'(byErr), 32'h0);
        applyStimulus(1'b1, 4'd5, 16'h6666, 1'b0, 4'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("r5Cleared", 32'(byBusyVec), 32'h0);

        // Write to idle R7 pulses the error flag for exactly one cycle
        applyStimulus(1'b1, 4'd7, 16'h1234, 1'b0, 4'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        rdAIndex = 4'd7;
        #1;
        checkOutput("r7Data", 32'(byARdData), 32'h1234);
        checkOutput("r7Ready", 32'(byAReady), 32'h1);
        checkOutput("r7ErrPulse", 32'(byErr), 32'h1);
        tick();
        checkOutput("r7ErrGone", 32'(byErr), 32'h0);

        // Writes to R0 are dropped silently
        rdAIndex = 4'd0;
        applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        checkOutput("r0WrData", 32'(byARdData), 32'h0);
        checkOutput("r0WrReady", 32'(byAReady), 32'h1);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("r0AfterData", 32'(byARdData), 32'h0);
        checkOutput("r0NoErr", 32'(byErr), 32'h0);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0);
        checkOutput("r0IssStall", 32'(byStall), 32'h0);
        tick();
        checkOutput("r0IssBusyVec", 32'(byBusyVec), 32'h0);

        // Three outstanding producers, then flush beats a same-cycle issue
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0);
        tick();
        checkOutput("threeBusyVec", 32'(byBusyVec), 32'h0016);
        checkOutput("threeCount", 32'(byBusyCount), 32'h3);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b1);
        checkOutput("flushStall", 32'(byStall), 32'h0);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("flushBusyVec", 32'(byBusyVec), 32'h0);
        checkOutput("flushCount", 32'(byBusyCount), 32'h0);

        // Non-bypass build shows the old value until the next cycle
        rdAIndex = 4'd9;
        applyStimulus(1'b1, 4'd9, 16'h00AA, 1'b0, 4'd0, 1'b0);
        checkOutput("nbR9Old", 32'(nbARdData), 32'h0);
        checkOutput("nbR9Ready", 32'(nbAReady), 32'h1);
        checkOutput("byR9New", 32'(byARdData), 32'h00AA);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("nbR9Next", 32'(nbARdData), 32'h00AA);
        checkOutput("nbR9Err", 32'(nbErr), 32'h1);

        // Mid-cycle async reset clears state without a clock edge
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        rdAIndex = 4'd7;
        #1;
        checkOutput("preRstBusy", 32'(byBusyVec), 32'h0400);
        checkOutput("preRstData", 32'(byARdData), 32'h1234);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 32'(byBusyVec), 32'h0);
        checkOutput("midRstCount", 32'(byBusyCount), 32'h0);
        checkOutput("midRstData", 32'(byARdData), 32'h0);
        tick();
        reset_n = 1'b1;
        rdAIndex = 4'd2;
        applyStimulus(1'b1, 4'd2, 16'h0F0F, 1'b0, 4'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
        checkOutput("postRstData", 32'(byARdData), 32'h0F0F);
        checkOutput("postRstErr", 32'(byErr), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
